// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// requester IDs and the default mapped window.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  localparam int DEF_MEM_BASE  = 1024;
  localparam int DEF_MEM_LIMIT = 1050;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester channels plus the single-port memory channel.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  done0, done1;
  logic                  err0, err1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           mem_wr_en, mem_addr, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           mem_wr_en, mem_addr, mem_din
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the requester that did not win
// last time is chosen; a lone requester always wins.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic any
);

  always_comb begin
    any = req0 | req1;
    if (req0 && req1) winner = ~last;
    else if (req1)    winner = REQ_DMA;
    else              winner = REQ_CORE;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin scheduler for the single-port data memory: range/alignment
// check, 1-cycle registered read sequencing, per-requester responses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BASE   = DEF_MEM_BASE,
  parameter int MEM_LIMIT  = DEF_MEM_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    bus
);

  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(MEM_BASE);
  localparam logic [ADDR_WIDTH-1:0] LIMIT_A = ADDR_WIDTH'(MEM_LIMIT);

  state_t                state, state_next;
  logic                  last, last_next;
  logic                  id_q, id_next;
  logic                  we_q, we_next;
  logic                  bad_q, bad_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic [DATA_WIDTH-1:0] din_q, din_next;

  logic                  wr_en_q, wr_en_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic                  winner, any;
  logic                  we_w, bad_w;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] wdata_w;
  logic                  resp_fire;
  logic [DATA_WIDTH-1:0] resp_data;

  rr_arb2 u_rr (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  // Winner's request fields and its range/alignment verdict.
  always_comb begin
    we_w    = (winner == REQ_DMA) ? bus.we1    : bus.we0;
    addr_w  = (winner == REQ_DMA) ? bus.addr1  : bus.addr0;
    wdata_w = (winner == REQ_DMA) ? bus.wdata1 : bus.wdata0;
    bad_w   = (addr_w < BASE_A) | (addr_w >= LIMIT_A) | (addr_w[1:0] != 2'b00);
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; an unassigned path in always_comb infers a latch.
  always_comb begin
    state_next = state;
    last_next  = last;
    id_next    = id_q;
    we_next    = we_q;
    bad_next   = bad_q;
    addr_next  = addr_q;
    din_next   = din_q;
    wr_en_d    = 1'b0;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    resp_fire  = 1'b0;
    resp_data  = '0;

    case (state)
      IDLE: begin
        if (any) begin
          state_next = ISSUE;
          last_next  = winner;
          id_next    = winner;
          we_next    = we_w;
          bad_next   = bad_w;
          addr_next  = addr_w;
          din_next   = wdata_w;
          wr_en_d    = we_w & ~bad_w;
          gnt0_d     = (winner == REQ_CORE);
          gnt1_d     = (winner == REQ_DMA);
        end
      end
      ISSUE: begin
        if (bad_q || we_q) begin
          state_next = RESP;
          resp_fire  = 1'b1;
        end else begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        state_next = RESP;
        resp_fire  = 1'b1;
        resp_data  = bus.mem_dout;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Response registers load on entry to RESP and clear on the way out.
    done0_d  = resp_fire & (id_q == REQ_CORE);
    done1_d  = resp_fire & (id_q == REQ_DMA);
    err0_d   = done0_d & bad_q;
    err1_d   = done1_d & bad_q;
    rdata0_d = done0_d ? resp_data : '0;
    rdata1_d = done1_d ? resp_data : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= REQ_DMA;
      id_q     <= REQ_CORE;
      we_q     <= 1'b0;
      bad_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      wr_en_q  <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state    <= state_next;
      last     <= last_next;
      id_q     <= id_next;
      we_q     <= we_next;
      bad_q    <= bad_next;
      addr_q   <= addr_next;
      din_q    <= din_next;
      wr_en_q  <= wr_en_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = din_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural 1-cycle-latency memory,
// reference memory image, and grant/response scoreboards.
module tb_dmem_arbiter;

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        gnt_q [$];
  resp_t       resp_q [$];
  resp_t       mon_r;
  logic        wr_seen;

  dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  dmem_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MEM_BASE   (1024),
    .MEM_LIMIT  (1050)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return (a < 32'd1024) || (a >= 32'd1050) || (a[1:0] != 2'b00);
  endfunction

  // Memory: write and registered read on the same edge.
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr[11:2]] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr[11:2]];
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.gnt0 || bus.gnt1) begin
        check("gnt_onehot", {63'd0, bus.gnt0 & bus.gnt1}, 64'd0);
        if (gnt_q.size() == 0) check("gnt_unexpected", 64'd1, 64'd0);
        else check("gnt_order", {63'd0, bus.gnt1}, {63'd0, gnt_q.pop_front()});
      end
      if (bus.done0 || bus.done1) begin
        check("done_onehot", {63'd0, bus.done0 & bus.done1}, 64'd0);
        if (resp_q.size() == 0) begin
          check("done_unexpected", 64'd1, 64'd0);
        end else begin
          mon_r = resp_q.pop_front();
          check("done_id", {63'd0, bus.done1}, {63'd0, mon_r.id});
          check("err", {63'd0, mon_r.id ? bus.err1 : bus.err0}, {63'd0, mon_r.err});
          check("rdata", {32'd0, mon_r.id ? bus.rdata1 : bus.rdata0}, {32'd0, mon_r.rdata});
          check("other_side_zero",
                mon_r.id ? {31'd0, bus.err0, bus.rdata0} : {31'd0, bus.err1, bus.rdata1}, 64'd0);
        end
      end
      if (bus.mem_wr_en) begin
        wr_seen = 1'b1;
        check("wr_in_window", {63'd0, addr_bad(bus.mem_addr)}, 64'd0);
      end
    end
  end

  // Expected grant/response for one transaction; updates the reference image.
  task automatic expect_txn(input logic id, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    resp_t r;
    logic  bad;
    bad     = addr_bad(addr);
    r.id    = id;
    r.err   = bad;
    r.rdata = (!we && !bad) ? ref_mem[addr[11:2]] : 32'd0;
    if (we && !bad) ref_mem[addr[11:2]] = wdata;
    gnt_q.push_back(id);
    resp_q.push_back(r);
  endtask

  task automatic drive(input logic id, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (id) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  // Single access from IDLE with cycle-exact latency checks; returns in IDLE.
  task automatic access(input string tag, input logic id, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic bad;
    int   dc;
    bad = addr_bad(addr);
    dc  = (we || bad) ? 2 : 3;
    expect_txn(id, we, addr, wdata);
    @(negedge clk);
    drive(id, 1'b1, we, addr, wdata);
    @(posedge clk); #1;
    check({tag, "_gnt_c1"}, {63'd0, id ? bus.gnt1 : bus.gnt0}, 64'd1);
    check({tag, "_wren_c1"}, {63'd0, bus.mem_wr_en}, {63'd0, we & ~bad});
    check({tag, "_maddr_c1"}, {32'd0, bus.mem_addr}, {32'd0, addr});
    drive(id, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int c = 2; c <= dc; c++) begin
      @(posedge clk); #1;
      check({tag, (c == dc) ? "_done_at" : "_done_early"},
            {63'd0, id ? bus.done1 : bus.done0}, (c == dc) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1;
  endtask

  // Bounded wait until every expected response has been seen.
  task automatic drain(input string tag);
    int k;
    k = 0;
    while (resp_q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_drained"}, 64'(resp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1,
                bus.mem_wr_en, bus.mem_addr, 25'd0}, 64'd0);
    check({tag, "_data"}, {bus.rdata0 | bus.rdata1 | bus.mem_din, 32'd0}, 64'd0);
  endtask

  initial begin
    int ngnt;
    logic [31:0] prior;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA500_0000 + i;
      ref_mem[i] = 32'hA500_0000 + i;
    end
    wr_seen = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // 1/2: core write then readback
    access("t1_wr", 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF);
    access("t2_rd", 1'b0, 1'b0, 32'd1028, 32'd0);
    drain("t12");

    // 3: both held from reset -> 0,1,0,1
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_txn(1'b0, 1'b0, 32'd1024, 32'd0);
      expect_txn(1'b1, 1'b0, 32'd1032, 32'd0);
    end
    drive(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0);
    ngnt = 0;
    for (int k = 0; k < 60 && ngnt < 4; k++) begin
      @(posedge clk); #1;
      if (bus.gnt0 || bus.gnt1) ngnt++;
    end
    check("t3_four_grants", 64'(ngnt), 64'd4);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drain("t3");
    check("t3_gnt_q_empty", 64'(gnt_q.size()), 64'd0);

    // 4: DMA bad writes never reach memory; window unchanged
    wr_seen = 1'b0;
    access("t4_oor", 1'b1, 1'b1, 32'd2048, 32'h1111_1111);
    access("t4_mis", 1'b1, 1'b1, 32'd1030, 32'h2222_2222);
    check("t4_no_mem_write", {63'd0, wr_seen}, 64'd0);
    for (int a = 1024; a <= 1048; a += 4)
      access("t4_rb", 1'b1, 1'b0, 32'(a), 32'd0);
    access("t4_top_bad", 1'b0, 1'b0, 32'd1052, 32'd0);
    drain("t4");

    // 5: reset during ISSUE of a core write aborts it
    prior = ref_mem[1036 >> 2];
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'd1036, 32'h5555_AAAA);
    @(posedge clk); #1;
    check("t5_issue_wren", {63'd0, bus.mem_wr_en}, 64'd1);
    reset = 1'b1;
    #1;
    check_all_zero("t5_abort");
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    access("t5_rd", 1'b0, 1'b0, 32'd1036, 32'd0);
    check("t5_ref_unchanged", {32'd0, ref_mem[1036 >> 2]}, {32'd0, prior});
    drain("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester scheduler for the single-port data memory.
- Requester 0 is the core load/store unit; requester 1 is the DMA/debug port.
- Arbitrates round-robin and range-checks each byte address against the mapped window.
- Sequences the memory's 1-cycle registered read, then returns a per-requester done/err/rdata response.

Parameters:
DATA_WIDTH, 32, data word width in bits
ADDR_WIDTH, 32, byte-address width in bits
MEM_BASE, 1024, lowest mapped byte address (inclusive)
MEM_LIMIT, 1050, mapped upper byte address (exclusive)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req0, req1  input  1 each  access request; held with we/addr/wdata until gnt
we0, we1  input  1 each  1 = write, 0 = read
addr0, addr1  input  ADDR_WIDTH each  byte address
wdata0, wdata1  input  DATA_WIDTH each  write data
gnt0, gnt1  output  1 each  one-cycle pulse; request accepted
done0, done1  output  1 each  one-cycle completion pulse
err0, err1  output  1 each  valid with done; out-of-range or misaligned
rdata0, rdata1  output  DATA_WIDTH each  read data, valid with done
mem_wr_en  output  1  to memory wr_en
mem_addr  output  ADDR_WIDTH  to memory addr
mem_din  output  DATA_WIDTH  to memory din
mem_dout  input  DATA_WIDTH  from memory dout (registered, 1-cycle latency)

Behaviour:
- Reset (async): state=IDLE; all gnt/done/err=0; rdata=0; mem_wr_en=0; mem_addr=0; mem_din=0; last=1, so requester 0 wins first.
- All outputs are registered. The memory is never written when not granted; mem_wr_en is 0 outside ISSUE.
- States: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE, no req: stay.
- IDLE, only one req: that requester wins.
- IDLE, both req: the requester != last wins; last <= winner.
- IDLE, on a win: latch id, we, addr, wdata; gnt_id<=1 for one cycle; compute bad = (addr<MEM_BASE) | (addr>=MEM_LIMIT) | (addr[1:0]!=0); go to ISSUE.
- ISSUE: mem_addr=addr and mem_din=wdata are presented this cycle.
  - mem_wr_en=1 only if we & ~bad.
  - Next state: bad or write -> RESP; good read -> RD_WAIT.
- RD_WAIT: memory output settles; capture mem_dout into rdata_id at the end of the cycle; go to RESP.
- RESP: done_id=1 for one cycle.
  - err_id=bad.
  - rdata_id = captured data for a good read, else 0.
  - The other requester's done/err/rdata stay 0.
  - Go to IDLE; a new grant can be issued in the following IDLE cycle.
- Latency, counted from the cycle req is high in IDLE (cycle 0):
  - gnt in cycle 1.
  - Write or bad access: done in cycle 2.
  - Good read: done in cycle 3.
- A bad access never reaches memory; its mem_wr_en stays 0.
- Request withdrawn after gnt: ignored; the transaction completes.
- req high while not IDLE: not sampled; no gnt until the next IDLE.
- Back-to-back: with both req held continuously, grants strictly alternate 0,1,0,1.
- Reset mid-transaction: abort immediately; no done is issued; the memory write is suppressed if reset asserts during ISSUE.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE, ISSUE, RD_WAIT, RESP), requester ID constants (REQ_CORE=0, REQ_DMA=1), and the default MEM_BASE/MEM_LIMIT values.
- One sub-module, rr_arb2: combinational 2-way round-robin pick from req0, req1 and last. Outputs: winner and any.

Test Plan:
1. Core write 0xDEADBEEF to addr 1028 (req0 only) -> gnt0 in cycle 1; mem_wr_en=1 with mem_addr=1028 in cycle 1; done0=1, err0=0 in cycle 2.
2. Core read addr 1028 after test 1 -> gnt0 cycle 1; mem_wr_en=0 in cycle 1; done0=1 with rdata0=0xDEADBEEF in cycle 3.
3. req0 and req1 both held, reads at 1024 and 1032, from reset -> gnt0 first, then gnt1 at the next IDLE; 4 back-to-back transactions grant 0,1,0,1.
4. DMA write to addr 2048, then to 1030 (misaligned) -> each gets done1=1, err1=1 in cycle 2; mem_wr_en never 1; a readback of 1024..1048 is unchanged.
5. Reset asserted during ISSUE of a core write to 1036 -> all outputs 0 immediately; no done0; a later read of 1036 returns the prior value.
